// File: rtl/master_seq.sv
// rtl/master_seq.sv - time-tagged burst sequencer with command queue and DDS REQ/ACK handoff
module master_seq #(
    parameter int TW    = 64,
    parameter int FW    = 48,
    parameter int RW    = 32,
    parameter int IW    = 32,
    parameter int NW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic [TW-1:0] SYS_TIME,
    input  logic          SYS_TIME_UPDATE,
    input  logic          T1hz,
    input  logic          WR_DATA,
    input  logic [FW-1:0] MEM_DDS_freq,
    input  logic [FW-1:0] MEM_DDS_delta_freq,
    input  logic [RW-1:0] MEM_DDS_delta_rate,
    input  logic [TW-1:0] MEM_TIME_START,
    input  logic [NW-1:0] MEM_N_impuls,
    input  logic          MEM_TYPE_impulse,
    input  logic [IW-1:0] MEM_Tblank1,
    input  logic [IW-1:0] MEM_Interval_Ti,
    input  logic [IW-1:0] MEM_Tblank2,
    input  logic [IW-1:0] MEM_Interval_Tp,
    input  logic          ABORT,
    input  logic          ACK,
    output logic          REQ,
    output logic [FW-1:0] DDS_freq,
    output logic [FW-1:0] DDS_delta_freq,
    output logic [RW-1:0] DDS_delta_rate,
    output logic          DDS_start,
    output logic          En_Iz,
    output logic          En_Pr,
    output logic [TW-1:0] TIME,
    output logic          SYS_TIME_UPDATE_OK,
    output logic          FULL,
    output logic          EMPTY,
    output logic          BUSY,
    output logic          LATE_ERR,
    output logic          OVF_ERR
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [FW-1:0] freq, dfreq;
        logic [RW-1:0] rate;
        logic [TW-1:0] start;
        logic [NW-1:0] n;
        logic          coh;
        logic [IW-1:0] tb1, ti, tb2, tp;
    } cmd_t;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_LOAD, S_DREQ, S_DACK, S_BLANK1,
        S_EMIT, S_BLANK2, S_RECV, S_END, S_ABRT
    } state_t;

    state_t        state, state_n;
    logic [2:0]    t1_sync, upd_sync;
    logic          sec_edge, upd_edge;
    cmd_t          q [DEPTH];
    cmd_t          wr_cmd, head, cur;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          push, pop, late;
    logic [NW-1:0] cnt;
    logic [IW-1:0] ic;
    logic          emitted;

    // Bit 2 is the previous synchronised level, so the edge pulse lands on the third cycle.
    assign sec_edge = t1_sync[1] & ~t1_sync[2];
    assign upd_edge = upd_sync[1] & ~upd_sync[2];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            t1_sync            <= '0;
            upd_sync           <= '0;
            TIME               <= '0;
            SYS_TIME_UPDATE_OK <= 1'b0;
        end else begin
            t1_sync  <= {t1_sync[1:0], T1hz};
            upd_sync <= {upd_sync[1:0], SYS_TIME_UPDATE};
            if (upd_edge) begin
                SYS_TIME_UPDATE_OK <= 1'b0;
                TIME               <= TIME + TW'(1);
            end else if (sec_edge && !SYS_TIME_UPDATE_OK) begin
                SYS_TIME_UPDATE_OK <= 1'b1;
                TIME               <= SYS_TIME;
            end else begin
                TIME <= TIME + TW'(1);
            end
        end
    end

    assign wr_cmd = {MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate, MEM_TIME_START,
                     MEM_N_impuls, MEM_TYPE_impulse, MEM_Tblank1, MEM_Interval_Ti,
                     MEM_Tblank2, MEM_Interval_Tp};
    assign EMPTY  = (wr_ptr == rd_ptr);
    assign FULL   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head   = q[rd_ptr[AW-1:0]];
    assign push   = WR_DATA && !FULL;
    assign pop    = (state == S_WAIT) && (TIME >= head.start);
    assign late   = TIME > head.start;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            OVF_ERR <= 1'b0;
        end else begin
            if (push) begin
                q[wr_ptr[AW-1:0]] <= wr_cmd;
                wr_ptr            <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (WR_DATA && FULL) OVF_ERR <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (!EMPTY) state_n = S_WAIT;
            S_WAIT:   if (TIME == head.start) state_n = S_LOAD;
                      else if (late)          state_n = S_IDLE;
            S_LOAD:   state_n = (cnt == '0) ? S_IDLE : S_DREQ;
            S_DREQ:   if (ACK)  state_n = S_DACK;
            S_DACK:   if (!ACK) state_n = S_BLANK1;
            S_BLANK1: if (ic == '0) state_n = S_EMIT;
            S_EMIT:   if (ic == '0) state_n = S_BLANK2;
            S_BLANK2: if (ic == '0) state_n = S_RECV;
            S_RECV:   if (ic == '0) state_n = S_END;
            S_END:    state_n = (cnt == NW'(1)) ? S_IDLE : (cur.coh ? S_BLANK1 : S_DREQ);
            S_ABRT:   if (!ACK) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        // A handshake already acknowledged must see ACK fall before the DDS side is released.
        if (ABORT && state != S_IDLE && state != S_WAIT && state != S_ABRT)
            state_n = ((state == S_DREQ || state == S_DACK) && ACK) ? S_ABRT : S_IDLE;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cur            <= '0;
            cnt            <= '0;
            ic             <= '0;
            emitted        <= 1'b0;
            LATE_ERR       <= 1'b0;
            DDS_freq       <= '0;
            DDS_delta_freq <= '0;
            DDS_delta_rate <= '0;
        end else begin
            if (pop) begin
                cur     <= head;
                cnt     <= head.n;
                emitted <= 1'b0;
                if (late) LATE_ERR <= 1'b1;
                // Params are presented together with the first REQ cycle in LOAD.
                if (!late && head.n != '0) begin
                    DDS_freq       <= head.freq;
                    DDS_delta_freq <= head.dfreq;
                    DDS_delta_rate <= head.rate;
                end
            end
            if (state == S_END)  cnt     <= cnt - NW'(1);
            if (state == S_EMIT) emitted <= 1'b1;
            if (state_n != state) begin
                case (state_n)
                    S_BLANK1: ic <= cur.tb1;
                    S_EMIT:   ic <= cur.ti;
                    S_BLANK2: ic <= cur.tb2;
                    S_RECV:   ic <= cur.tp;
                    default:  ic <= '0;
                endcase
            end else if (ic != '0) begin
                ic <= ic - IW'(1);
            end
        end
    end

    always_comb begin
        REQ       = ((state == S_LOAD) && (cnt != '0)) || (state == S_DREQ);
        En_Iz     = (state == S_EMIT);
        En_Pr     = (state == S_RECV);
        BUSY      = (state != S_IDLE) && (state != S_WAIT);
        DDS_start = (state == S_EMIT) ||
                    (cur.coh && (((state == S_BLANK1) && emitted) ||
                                 (((state == S_BLANK2) || (state == S_RECV) || (state == S_END))
                                  && (cnt > NW'(1)))));
    end
endmodule

// File: tb/tb_master_seq.sv
// tb/tb_master_seq.sv - directed self-checking bench for master_seq
module tb_master_seq;
    localparam int TW = 64, FW = 48, RW = 32, IW = 32, NW = 16;

    logic          CLK = 1'b0, RESET_N = 1'b0;
    logic [TW-1:0] SYS_TIME = '0;
    logic          SYS_TIME_UPDATE = 1'b0, T1hz = 1'b0, WR_DATA = 1'b0;
    logic [FW-1:0] MEM_DDS_freq = '0, MEM_DDS_delta_freq = '0;
    logic [RW-1:0] MEM_DDS_delta_rate = '0;
    logic [TW-1:0] MEM_TIME_START = '0;
    logic [NW-1:0] MEM_N_impuls = '0;
    logic          MEM_TYPE_impulse = 1'b0;
    logic [IW-1:0] MEM_Tblank1 = '0, MEM_Interval_Ti = '0, MEM_Tblank2 = '0, MEM_Interval_Tp = '0;
    logic          ABORT = 1'b0, ACK = 1'b0;
    logic          REQ, DDS_start, En_Iz, En_Pr, SYS_TIME_UPDATE_OK, FULL, EMPTY, BUSY, LATE_ERR, OVF_ERR;
    logic [FW-1:0] DDS_freq, DDS_delta_freq;
    logic [RW-1:0] DDS_delta_rate;
    logic [TW-1:0] TIME;

    int n_cmp = 0, n_err = 0;
    int c_iz, c_pr, c_ds, c_ds_noiz, c_busy, r_req, r_ds;
    logic [TW-1:0] req_t, st;
    logic [FW-1:0] freq_log [$];

    master_seq dut (
        .CLK(CLK), .RESET_N(RESET_N), .SYS_TIME(SYS_TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE),
        .T1hz(T1hz), .WR_DATA(WR_DATA), .MEM_DDS_freq(MEM_DDS_freq),
        .MEM_DDS_delta_freq(MEM_DDS_delta_freq), .MEM_DDS_delta_rate(MEM_DDS_delta_rate),
        .MEM_TIME_START(MEM_TIME_START), .MEM_N_impuls(MEM_N_impuls),
        .MEM_TYPE_impulse(MEM_TYPE_impulse), .MEM_Tblank1(MEM_Tblank1),
        .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Tblank2(MEM_Tblank2),
        .MEM_Interval_Tp(MEM_Interval_Tp), .ABORT(ABORT), .ACK(ACK), .REQ(REQ),
        .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq), .DDS_delta_rate(DDS_delta_rate),
        .DDS_start(DDS_start), .En_Iz(En_Iz), .En_Pr(En_Pr), .TIME(TIME),
        .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK), .FULL(FULL), .EMPTY(EMPTY), .BUSY(BUSY),
        .LATE_ERR(LATE_ERR), .OVF_ERR(OVF_ERR)
    );

    always #10 CLK = ~CLK;

    // DDS-side responder: ACK 4 cycles after REQ, released 2 cycles after REQ falls.
    always begin
        @(negedge CLK);
        if (REQ === 1'b1 && ACK === 1'b0) begin
            repeat (4) @(negedge CLK);
            ACK = 1'b1;
            for (int i = 0; i < 50 && REQ === 1'b1; i++) @(negedge CLK);
            repeat (2) @(negedge CLK);
            ACK = 1'b0;
        end
    end

    task automatic push(input longint off, input logic [NW-1:0] n, input logic coh,
                        input logic [IW-1:0] tb1, input logic [IW-1:0] ti,
                        input logic [IW-1:0] tb2, input logic [IW-1:0] tp,
                        input logic [FW-1:0] freq, output logic [TW-1:0] start);
        @(negedge CLK);
        start = TIME + TW'(off);
        MEM_TIME_START = start; MEM_N_impuls = n; MEM_TYPE_impulse = coh;
        MEM_Tblank1 = tb1; MEM_Interval_Ti = ti; MEM_Tblank2 = tb2; MEM_Interval_Tp = tp;
        MEM_DDS_freq = freq; MEM_DDS_delta_freq = 48'h5; MEM_DDS_delta_rate = 32'h7;
        WR_DATA = 1'b1;
        @(negedge CLK);
        WR_DATA = 1'b0;
    endtask

    task automatic watch(input int cycles);
        logic pr, pd;
        c_iz = 0; c_pr = 0; c_ds = 0; c_ds_noiz = 0; c_busy = 0; r_req = 0; r_ds = 0;
        req_t = '0; freq_log.delete();
        pr = REQ; pd = DDS_start;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (En_Iz) c_iz++;
            if (En_Pr) c_pr++;
            if (BUSY) c_busy++;
            if (DDS_start) c_ds++;
            if (DDS_start && !En_Iz) c_ds_noiz++;
            if (DDS_start && !pd) r_ds++;
            if (REQ && !pr) begin
                r_req++;
                if (r_req == 1) req_t = TIME;
                freq_log.push_back(DDS_freq);
            end
            pr = REQ; pd = DDS_start;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLK);
        n_cmp++; if (TIME !== 64'd0) begin n_err++; $display("FAIL reset_time: got %0d expected 0", TIME); end
        n_cmp++; if ({EMPTY, FULL, BUSY, REQ, SYS_TIME_UPDATE_OK, LATE_ERR, OVF_ERR, En_Iz, En_Pr, DDS_start} !== 10'b1000000000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 1000000000",
                {EMPTY, FULL, BUSY, REQ, SYS_TIME_UPDATE_OK, LATE_ERR, OVF_ERR, En_Iz, En_Pr, DDS_start}); end
        RESET_N = 1'b1;
    endtask

    task automatic test_time_sync;
        SYS_TIME = 64'd1000;
        SYS_TIME_UPDATE = 1'b1; repeat (4) @(negedge CLK);
        SYS_TIME_UPDATE = 1'b0; repeat (4) @(negedge CLK);
        T1hz = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++; if (SYS_TIME_UPDATE_OK !== 1'b0) begin n_err++; $display("FAIL ok_early: got %b expected 0", SYS_TIME_UPDATE_OK); end
        @(negedge CLK);
        n_cmp++; if (TIME !== 64'd1000) begin n_err++; $display("FAIL time_load: got %0d expected 1000", TIME); end
        n_cmp++; if (SYS_TIME_UPDATE_OK !== 1'b1) begin n_err++; $display("FAIL ok_set: got %b expected 1", SYS_TIME_UPDATE_OK); end
        @(negedge CLK);
        n_cmp++; if (TIME !== 64'd1001) begin n_err++; $display("FAIL time_inc: got %0d expected 1001", TIME); end
        repeat (3) @(negedge CLK); T1hz = 1'b0;
        repeat (5) @(negedge CLK); T1hz = 1'b1;
        repeat (10) @(negedge CLK);
        n_cmp++; if (TIME !== 64'd1019) begin n_err++; $display("FAIL no_reload: got %0d expected 1019", TIME); end
        T1hz = 1'b0;
    endtask

    task automatic test_burst_noncoh;
        push(50, 16'd2, 1'b0, 32'd3, 32'd5, 32'd2, 32'd4, 48'h111, st);
        watch(150);
        n_cmp++; if (req_t !== st + 64'd1) begin n_err++; $display("FAIL nc_req_time: got %0d expected %0d", req_t, st + 64'd1); end
        n_cmp++; if (r_req != 2) begin n_err++; $display("FAIL nc_req_count: got %0d expected 2", r_req); end
        n_cmp++; if (c_iz != 12) begin n_err++; $display("FAIL nc_en_iz: got %0d expected 12", c_iz); end
        n_cmp++; if (c_pr != 10) begin n_err++; $display("FAIL nc_en_pr: got %0d expected 10", c_pr); end
        n_cmp++; if (c_ds != 12 || c_ds_noiz != 0) begin n_err++; $display("FAIL nc_dds_start: got %0d/%0d expected 12/0", c_ds, c_ds_noiz); end
        n_cmp++; if (DDS_freq !== 48'h111) begin n_err++; $display("FAIL nc_freq: got %h expected 111", DDS_freq); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL nc_done: got %b expected 0", BUSY); end
    endtask

    task automatic test_burst_coh;
        push(50, 16'd2, 1'b1, 32'd3, 32'd5, 32'd2, 32'd4, 48'h222, st);
        watch(150);
        n_cmp++; if (r_req != 1) begin n_err++; $display("FAIL c_req_count: got %0d expected 1", r_req); end
        n_cmp++; if (r_ds != 1 || c_ds != 25) begin n_err++; $display("FAIL c_dds_span: got %0d rises/%0d cycles expected 1/25", r_ds, c_ds); end
        n_cmp++; if (c_ds_noiz != 13) begin n_err++; $display("FAIL c_dds_hold: got %0d expected 13", c_ds_noiz); end
        n_cmp++; if (c_iz != 12 || c_pr != 10) begin n_err++; $display("FAIL c_enables: got %0d/%0d expected 12/10", c_iz, c_pr); end
    endtask

    task automatic test_queue_full;
        for (int i = 0; i < 4; i++)
            push(100 + 40 * i, 16'd1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, FW'(i + 1), st);
        n_cmp++; if (FULL !== 1'b1 || OVF_ERR !== 1'b0) begin n_err++; $display("FAIL q_full: got %b/%b expected 1/0", FULL, OVF_ERR); end
        push(300, 16'd1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 48'd5, st);
        n_cmp++; if (OVF_ERR !== 1'b1 || FULL !== 1'b1) begin n_err++; $display("FAIL q_ovf: got %b/%b expected 1/1", OVF_ERR, FULL); end
        watch(320);
        n_cmp++; if (r_req != 4) begin n_err++; $display("FAIL q_count: got %0d expected 4", r_req); end
        for (int i = 0; i < 4 && i < freq_log.size(); i++) begin
            n_cmp++; if (freq_log[i] !== FW'(i + 1)) begin n_err++; $display("FAIL q_order: got %0d expected %0d", freq_log[i], i + 1); end
        end
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL q_drain: got %b expected 1", EMPTY); end
    endtask

    task automatic test_late_and_zero;
        push(-10, 16'd1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 48'h77, st);
        watch(10);
        n_cmp++; if (LATE_ERR !== 1'b1 || EMPTY !== 1'b1) begin n_err++; $display("FAIL late: got %b/%b expected 1/1", LATE_ERR, EMPTY); end
        n_cmp++; if (r_req != 0 || c_busy != 0) begin n_err++; $display("FAIL late_quiet: got %0d/%0d expected 0/0", r_req, c_busy); end
        push(20, 16'd0, 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 48'h88, st);
        watch(40);
        n_cmp++; if (c_busy != 1) begin n_err++; $display("FAIL n0_busy: got %0d expected 1", c_busy); end
        n_cmp++; if (r_req + c_iz + c_pr + c_ds != 0) begin n_err++; $display("FAIL n0_quiet: got %0d expected 0", r_req + c_iz + c_pr + c_ds); end
    endtask

    task automatic test_abort;
        int seen;
        push(30, 16'd1, 1'b0, 32'd2, 32'd20, 32'd1, 32'd1, 48'hAA, st);
        push(120, 16'd1, 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 48'hBB, st);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin @(negedge CLK); if (En_Iz) seen = 1; end
        n_cmp++; if (seen != 1) begin n_err++; $display("FAIL ab_emit_timeout: got %0d expected 1", seen); end
        repeat (3) @(negedge CLK);
        ABORT = 1'b1; @(negedge CLK); ABORT = 1'b0;
        n_cmp++; if ({En_Iz, En_Pr, DDS_start, REQ, BUSY} !== 5'b0) begin n_err++; $display("FAIL ab_outputs: got %b expected 00000", {En_Iz, En_Pr, DDS_start, REQ, BUSY}); end
        n_cmp++; if (EMPTY !== 1'b0) begin n_err++; $display("FAIL ab_queue: got %b expected 0", EMPTY); end
        watch(150);
        n_cmp++; if (r_req != 1 || freq_log.size() != 1) begin n_err++; $display("FAIL ab_next_req: got %0d expected 1", r_req); end
        else begin n_cmp++; if (freq_log[0] !== 48'hBB) begin n_err++; $display("FAIL ab_next_freq: got %h expected bb", freq_log[0]); end end
        n_cmp++; if (c_iz != 2) begin n_err++; $display("FAIL ab_next_emit: got %0d expected 2", c_iz); end
    endtask

    task automatic test_reset_mid_recv;
        int seen;
        push(20, 16'd1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd20, 48'hCC, st);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin @(negedge CLK); if (En_Pr) seen = 1; end
        n_cmp++; if (seen != 1) begin n_err++; $display("FAIL rs_recv_timeout: got %0d expected 1", seen); end
        repeat (3) @(negedge CLK);
        RESET_N = 1'b0; #1;
        n_cmp++; if ({En_Iz, En_Pr, DDS_start, REQ, BUSY} !== 5'b0) begin n_err++; $display("FAIL rs_outputs: got %b expected 00000", {En_Iz, En_Pr, DDS_start, REQ, BUSY}); end
        n_cmp++; if (TIME !== 64'd0 || EMPTY !== 1'b1 || LATE_ERR !== 1'b0 || OVF_ERR !== 1'b0) begin
            n_err++; $display("FAIL rs_state: got time %0d empty %b late %b ovf %b expected 0 1 0 0", TIME, EMPTY, LATE_ERR, OVF_ERR); end
        @(negedge CLK); RESET_N = 1'b1;
    endtask

    initial begin
        test_reset;
        test_time_sync;
        test_burst_noncoh;
        test_burst_coh;
        test_queue_full;
        test_late_and_zero;
        test_abort;
        test_reset_mid_recv;
        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/master_seq.md
Name: master_seq

Overview:
- Parametrised successor of the single-command burst starter. Keeps a free-running system time counter that is re-aligned to the 1 Hz second mark.
- Holds a DEPTH-entry queue of time-tagged burst commands and executes each at its start time. A burst is N repeated blank1/emit/blank2/receive cycles.
- Hands DDS parameters to the DDS clock domain over a 4-phase REQ/ACK handshake.
- Sits between the real-time command register and dds_chirp / RF switching.

Parameters:
TW, 64, width of system time and start-time fields
FW, 48, DDS frequency and delta-frequency width
RW, 32, DDS delta-rate width
IW, 32, width of the Tblank1/Ti/Tblank2/Tp interval counters
NW, 16, pulse-count width
DEPTH, 4, command queue depth (power of 2, >=2)

Ports:
CLK  in  1  system clock, 48 MHz
RESET_N  in  1  async active-low reset
SYS_TIME  in  TW  time value loaded at the next second mark
SYS_TIME_UPDATE  in  1  arms time reload (async, rising edge)
T1hz  in  1  second mark (async, rising edge)
WR_DATA  in  1  push one command (1-cycle strobe)
MEM_DDS_freq / MEM_DDS_delta_freq  in  FW  DDS start frequency / step
MEM_DDS_delta_rate  in  RW  DDS sweep rate
MEM_TIME_START  in  TW  burst start time
MEM_N_impuls  in  NW  pulses in burst
MEM_TYPE_impulse  in  1  0 = non-coherent, 1 = coherent
MEM_Tblank1 / MEM_Interval_Ti / MEM_Tblank2 / MEM_Interval_Tp  in  IW  interval lengths
ABORT  in  1  sync abort of the running burst
ACK  in  1  DDS-domain acknowledge (already synchronised)
REQ  out  1  DDS parameter request
DDS_freq / DDS_delta_freq  out  FW  held DDS params
DDS_delta_rate  out  RW  held DDS rate
DDS_start  out  1  DDS run enable
En_Iz / En_Pr  out  1  emit / receive enables
TIME  out  TW  current system time
SYS_TIME_UPDATE_OK  out  1  time reloaded since last arm
FULL / EMPTY  out  1  queue status
BUSY  out  1  burst in progress (state not IDLE/WAIT)
LATE_ERR / OVF_ERR  out  1  sticky: command dropped late / push while full

Behaviour:
- **Reset:** RESET_N=0 asynchronously clears all outputs and registers to 0, TIME=0, queue empty (EMPTY=1), state IDLE.
- **Edge detection:** T1hz and SYS_TIME_UPDATE each pass a 2-FF synchroniser followed by a rising-edge detect, giving 3-cycle latency from the input edge.
- **Time counter:**
  - Update edge: clears OK, and TIME still increments that cycle.
  - Else, second-mark edge with OK=0: TIME<=SYS_TIME and OK<=1.
  - Else: TIME<=TIME+1, wrapping mod 2^TW.
  - Simultaneous update and mark edges: the update edge wins.
- **Queue:**
  - WR_DATA with FULL=0 pushes all MEM_* fields.
  - WR_DATA with FULL=1 is ignored and sets OVF_ERR.
  - A push and a pop in the same cycle are both allowed.
- **FSM:**
  - IDLE: if !EMPTY, go to WAIT.
  - WAIT: compares the head's start time with TIME.
    - TIME==start: pop, load the pulse counter with N, go to LOAD.
    - TIME>start (unsigned, e.g. after a time reload): pop, set LATE_ERR, go to IDLE.
  - LOAD:
    - N==0: go to IDLE (no REQ, no enables).
    - Else: latch DDS outputs from the popped entry, assert REQ, go to DREQ.
  - DREQ: hold REQ=1 until ACK=1, then drop REQ. Wait for ACK=0, then go to BLANK1. REQ never re-rises while ACK=1.
  - BLANK1: Tblank1+1 cycles, then EMIT.
  - EMIT: Ti+1 cycles. DDS_start=1 and En_Iz=1 from the first EMIT cycle.
  - BLANK2: Tblank2+1 cycles. En_Iz=0. DDS_start=0 if type=0 or this is the last pulse; held if coherent and pulses remain.
  - RECV: Tp+1 cycles, En_Pr=1.
  - END (1 cycle): En_Pr=0, decrement the pulse counter. If it reaches 0: DDS_start=0 and go to IDLE. Else: type=0 goes to DREQ (re-send params), type=1 goes to BLANK1.
- **Interval counting:** each interval counter is loaded with its value on entry and counts down to 0 inclusive. An interval of 0 therefore lasts 1 cycle.
- **ABORT:** sampled in any state after WAIT. Forces En_Iz=En_Pr=DDS_start=REQ=0 and goes to IDLE the next cycle. The queue is untouched.
  - If ABORT arrives in DREQ with ACK=1, the FSM first waits for ACK=0 before IDLE.
- **Error flags:** LATE_ERR and OVF_ERR clear only on reset.

Test Plan:
- SYS_TIME=1000, pulse SYS_TIME_UPDATE, then T1hz -> TIME=1000 exactly 3 cycles after the T1hz edge and OK=1. A second T1hz with no re-arm leaves TIME counting, no reload.
- Push start=TIME+50, N=2, Tb1=3, Ti=5, Tb2=2, Tp=4, type=0 -> REQ at start+1. With ACK answering after 4 cycles: En_Iz high 6 cycles, En_Pr high 5 cycles, two REQ cycles, DDS_start low in each BLANK2.
- Same with type=1 -> a single REQ; DDS_start continuous from the first EMIT until the last BLANK2.
- Push 5 commands with DEPTH=4 -> FULL after the 4th, OVF_ERR=1; the first 4 execute in order.
- Push start=TIME-10 -> LATE_ERR=1, no REQ, queue advances. N=0 command -> no enables, BUSY pulses for 1 cycle only.
- ABORT mid-EMIT, and RESET_N low mid-RECV -> all enables 0 next cycle (ABORT) or immediately (reset); the next queued command still runs after ABORT.
